// File: rtl/imem_pkg.sv
// Shared types and helpers for the dual-bank instruction memory.
package imem_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [30:0] row;
        logic        bank;
    } addr_split_t;

    // Word address -> (row within bank, bank select); even words live in bank 0.
    function automatic addr_split_t split_addr(input logic [31:0] addr);
        addr_split_t s;
        s.row  = addr[31:1];
        s.bank = addr[0];
        return s;
    endfunction

endpackage

// File: rtl/imem_bank.sv
// One interleaved bank: 1 write / 1 read synchronous RAM with a registered read port.
module imem_bank #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned ROWS   = 512,
    localparam int unsigned ROW_W  = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ROW_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ROW_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [ROWS];
    logic [DATA_W-1:0] rdata_q;

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_dual_bank.sv
// Dual-bank instruction memory: load sequencer FSM, pair-write steering and 1-cycle pair fetch.
module imem_dual_bank
    import imem_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_pair,
    input  logic [DATA_W-1:0] ld_data0,
    input  logic [DATA_W-1:0] ld_data1,
    input  logic              ld_last,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_err,
    output logic              busy,
    input  logic              fetch_req,
    output logic              fetch_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_pair,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1
);

    localparam int unsigned ROW_W = ADDR_W - 1;
    localparam int unsigned ROWS  = DEPTH / 2;
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  ld_count_q, ld_count_d;
    logic              ld_err_q, ld_err_d;
    logic              rd_valid_q;
    logic              rd_odd_q;
    logic              rd_pair_q;

    addr_split_t       ld_sp, f_sp;
    logic [ROW_W-1:0]  w_row, w_row_p1, f_row, f_row_p1;
    logic              w_odd, f_odd;
    logic              beat_acc, at_top, wr_second, fetch_acc;
    logic              unused_split;

    logic              b0_we, b1_we;
    logic [ROW_W-1:0]  b0_waddr, b0_raddr;
    logic [DATA_W-1:0] b0_wdata, b1_wdata, b0_rdata, b1_rdata;

    assign ld_sp        = split_addr(32'(ld_addr));
    assign f_sp         = split_addr(32'(fetch_addr));
    assign w_row        = ROW_W'(ld_sp.row);
    assign f_row        = ROW_W'(f_sp.row);
    assign w_odd        = ld_sp.bank;
    assign f_odd        = f_sp.bank;
    assign w_row_p1     = w_row + ROW_W'(1);
    assign f_row_p1     = f_row + ROW_W'(1);
    assign unused_split = ^{ld_sp.row[30:ROW_W], f_sp.row[30:ROW_W]};

    assign ld_ready    = (state_q == ST_LOAD);
    assign busy        = (state_q == ST_LOAD);
    assign fetch_ready = (state_q == ST_RUN);

    // A beat arriving alongside load_start is dropped by the session restart.
    assign beat_acc  = ld_ready && ld_valid && !load_start;
    assign at_top    = (ld_addr == ADDR_W'(DEPTH - 1));
    assign wr_second = beat_acc && ld_pair && !at_top;
    assign fetch_acc = fetch_req && fetch_ready;

    // Odd start address: first word lands in bank 1, second in bank 0 one row up.
    assign b0_we    = beat_acc && (!w_odd || wr_second);
    assign b0_waddr = w_odd ? w_row_p1 : w_row;
    assign b0_wdata = w_odd ? ld_data1 : ld_data0;
    assign b1_we    = beat_acc && (w_odd || wr_second);
    assign b1_wdata = w_odd ? ld_data0 : ld_data1;
    assign b0_raddr = f_odd ? f_row_p1 : f_row;

    imem_bank #(.DATA_W(DATA_W), .ROWS(ROWS)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (b0_we),
        .waddr_i (b0_waddr),
        .wdata_i (b0_wdata),
        .re_i    (fetch_acc),
        .raddr_i (b0_raddr),
        .rdata_o (b0_rdata)
    );

    imem_bank #(.DATA_W(DATA_W), .ROWS(ROWS)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (b1_we),
        .waddr_i (w_row),
        .wdata_i (b1_wdata),
        .re_i    (fetch_acc),
        .raddr_i (f_row),
        .rdata_o (b1_rdata)
    );

    always_comb begin
        state_d    = state_q;
        ld_count_d = ld_count_q;
        ld_err_d   = ld_err_q;
        case (state_q)
            ST_IDLE: if (load_start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end else if (beat_acc && ld_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  if (load_start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
        if (load_start) begin
            ld_count_d = '0;
            ld_err_d   = 1'b0;
        end else if (beat_acc) begin
            ld_count_d = ld_count_q + (wr_second ? CNT_W'(2) : CNT_W'(1));
            ld_err_d   = ld_err_q || (ld_pair && at_top);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ld_count_q <= '0;
            ld_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_odd_q   <= 1'b0;
            rd_pair_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_count_q <= ld_count_d;
            ld_err_q   <= ld_err_d;
            rd_valid_q <= fetch_acc;
            if (fetch_acc) begin
                rd_odd_q  <= f_odd;
                rd_pair_q <= fetch_pair;
            end
        end
    end

    assign ld_count = ld_count_q;
    assign ld_err   = ld_err_q;
    assign rd_valid = rd_valid_q;
    assign rd_data0 = rd_odd_q ? b1_rdata : b0_rdata;
    assign rd_data1 = !rd_pair_q ? '0 : (rd_odd_q ? b0_rdata : b1_rdata);

endmodule

// File: tb/tb_imem_dual_bank.sv
// Directed bench for imem_dual_bank: load sessions, pair routing, boundaries and fetch timing.
module tb_imem_dual_bank;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst, load_start, ld_valid, ld_ready, ld_pair, ld_last, ld_err, busy;
    logic [ADDR_W-1:0] ld_addr, fetch_addr;
    logic [DATA_W-1:0] ld_data0, ld_data1, rd_data0, rd_data1;
    logic [ADDR_W:0]   ld_count;
    logic              fetch_req, fetch_ready, fetch_pair, rd_valid;

    int checks = 0;
    int errors = 0;

    imem_dual_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_pair(ld_pair), .ld_data0(ld_data0), .ld_data1(ld_data1),
        .ld_last(ld_last), .ld_count(ld_count), .ld_err(ld_err), .busy(busy),
        .fetch_req(fetch_req), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
        .fetch_pair(fetch_pair), .rd_valid(rd_valid), .rd_data0(rd_data0), .rd_data1(rd_data1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [ADDR_W-1:0] a, input logic p,
                            input logic [31:0] d0, input logic [31:0] d1, input logic last);
        ld_valid = v; ld_addr = a; ld_pair = p; ld_data0 = d0; ld_data1 = d1; ld_last = last;
    endtask

    task automatic set_fetch(input logic req, input logic [ADDR_W-1:0] a, input logic p);
        fetch_req = req; fetch_addr = a; fetch_pair = p;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 1'b0;
        set_beat(1'b0, '0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_fetch(1'b0, '0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if ({ld_ready, busy, fetch_ready, rd_valid, ld_err} !== 5'b0) begin errors++;
            $display("FAIL reset_flags got %b exp 00000", {ld_ready, busy, fetch_ready, rd_valid, ld_err}); end
        checks++; if (ld_count !== 11'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ld_count); end
        checks++; if ({rd_data0, rd_data1} !== 64'h0) begin errors++;
            $display("FAIL reset_rd_data got %h/%h exp 0/0", rd_data0, rd_data1); end
    endtask

    task automatic test_load_basic();
        load_start = 1'b1; tick(); load_start = 1'b0;
        checks++; if ({busy, ld_ready, ld_count} !== {2'b11, 11'd0}) begin errors++;
            $display("FAIL load_enter got busy=%b rdy=%b cnt=%0d exp 1 1 0", busy, ld_ready, ld_count); end
        set_beat(1'b1, 10'd0, 1'b1, 32'h11, 32'h22, 1'b0); tick();
        set_beat(1'b1, 10'd2, 1'b1, 32'h33, 32'h44, 1'b1); tick();
        set_beat(1'b0, '0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if ({ld_count, ld_err, busy, fetch_ready} !== {11'd4, 3'b001}) begin errors++;
            $display("FAIL load_done got cnt=%0d err=%b busy=%b frdy=%b exp 4 0 0 1", ld_count, ld_err, busy, fetch_ready); end
        set_fetch(1'b1, 10'd1, 1'b1); tick(); set_fetch(1'b0, '0, 1'b0);
        checks++; if ({rd_valid, rd_data0, rd_data1} !== {1'b1, 32'h22, 32'h33}) begin errors++;
            $display("FAIL fetch_pair1 got v=%b %h/%h exp 1 22/33", rd_valid, rd_data0, rd_data1); end
        tick();
        checks++; if ({rd_valid, rd_data0, rd_data1} !== {1'b0, 32'h22, 32'h33}) begin errors++;
            $display("FAIL rd_hold got v=%b %h/%h exp 0 22/33", rd_valid, rd_data0, rd_data1); end
    endtask

    task automatic test_odd_pair();
        load_start = 1'b1; tick(); load_start = 1'b0;
        set_beat(1'b1, 10'd5, 1'b1, 32'hAA, 32'hBB, 1'b1); tick();
        set_beat(1'b0, '0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if ({ld_count, busy} !== {11'd2, 1'b0}) begin errors++;
            $display("FAIL odd_count got cnt=%0d busy=%b exp 2 0", ld_count, busy); end
        set_fetch(1'b1, 10'd5, 1'b1); tick();
        checks++; if ({rd_valid, rd_data0, rd_data1} !== {1'b1, 32'hAA, 32'hBB}) begin errors++;
            $display("FAIL odd_fetch5 got v=%b %h/%h exp 1 aa/bb", rd_valid, rd_data0, rd_data1); end
        set_fetch(1'b1, 10'd6, 1'b0); tick(); set_fetch(1'b0, '0, 1'b0);
        checks++; if ({rd_valid, rd_data0, rd_data1} !== {1'b1, 32'hBB, 32'h0}) begin errors++;
            $display("FAIL single6 got v=%b %h/%h exp 1 bb/0", rd_valid, rd_data0, rd_data1); end
    endtask

    task automatic test_top_boundary();
        load_start = 1'b1; tick(); load_start = 1'b0;
        set_beat(1'b1, 10'd8, 1'b0, 32'h55, 32'hFF, 1'b0); tick();
        checks++; if ({ld_count, ld_err} !== {11'd1, 1'b0}) begin errors++;
            $display("FAIL top_pre got cnt=%0d err=%b exp 1 0", ld_count, ld_err); end
        set_beat(1'b1, 10'd1023, 1'b1, 32'hCC, 32'hDD, 1'b1); tick();
        set_beat(1'b0, '0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if ({ld_count, ld_err} !== {11'd2, 1'b1}) begin errors++;
            $display("FAIL top_err got cnt=%0d err=%b exp 2 1", ld_count, ld_err); end
        set_fetch(1'b1, 10'd1023, 1'b1); tick(); set_fetch(1'b0, '0, 1'b0);
        checks++; if ({rd_valid, rd_data0, rd_data1} !== {1'b1, 32'hCC, 32'h11}) begin errors++;
            $display("FAIL fetch_wrap got v=%b %h/%h exp 1 cc/11", rd_valid, rd_data0, rd_data1); end
    endtask

    task automatic test_blocked_and_b2b();
        rst = 1'b1; tick(); rst = 1'b0;
        set_fetch(1'b1, 10'd0, 1'b1);
        tick(); tick();
        checks++; if ({fetch_ready, rd_valid} !== 2'b00) begin errors++;
            $display("FAIL idle_block got frdy=%b v=%b exp 0 0", fetch_ready, rd_valid); end
        load_start = 1'b1; tick(); load_start = 1'b0; tick();
        checks++; if ({fetch_ready, rd_valid, busy} !== 3'b001) begin errors++;
            $display("FAIL load_block got frdy=%b v=%b busy=%b exp 0 0 1", fetch_ready, rd_valid, busy); end
        set_fetch(1'b0, '0, 1'b0);
        set_beat(1'b1, 10'd10, 1'b1, 32'h66, 32'h77, 1'b1); tick();
        set_beat(1'b0, '0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_fetch(1'b1, 10'd0, 1'b1); tick();
        checks++; if ({rd_valid, rd_data0, rd_data1} !== {1'b1, 32'h11, 32'h22}) begin errors++;
            $display("FAIL b2b_0 got v=%b %h/%h exp 1 11/22", rd_valid, rd_data0, rd_data1); end
        set_fetch(1'b1, 10'd5, 1'b1); tick();
        checks++; if ({rd_valid, rd_data0, rd_data1} !== {1'b1, 32'hAA, 32'hBB}) begin errors++;
            $display("FAIL b2b_5 got v=%b %h/%h exp 1 aa/bb", rd_valid, rd_data0, rd_data1); end
        set_fetch(1'b1, 10'd10, 1'b1); tick();
        checks++; if ({rd_valid, rd_data0, rd_data1} !== {1'b1, 32'h66, 32'h77}) begin errors++;
            $display("FAIL b2b_10 got v=%b %h/%h exp 1 66/77", rd_valid, rd_data0, rd_data1); end
        set_fetch(1'b1, 10'd2, 1'b0); tick();
        checks++; if ({rd_valid, rd_data0, rd_data1} !== {1'b1, 32'h33, 32'h0}) begin errors++;
            $display("FAIL b2b_2 got v=%b %h/%h exp 1 33/0", rd_valid, rd_data0, rd_data1); end
        set_fetch(1'b0, '0, 1'b0); tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got v=%b exp 0", rd_valid); end
    endtask

    task automatic test_abandon_restart();
        set_fetch(1'b1, 10'd3, 1'b0); load_start = 1'b1; tick();
        set_fetch(1'b0, '0, 1'b0); load_start = 1'b0;
        checks++; if ({rd_valid, rd_data0, busy, ld_count} !== {1'b1, 32'h44, 1'b1, 11'd0}) begin errors++;
            $display("FAIL abandon got v=%b d0=%h busy=%b cnt=%0d exp 1 44 1 0", rd_valid, rd_data0, busy, ld_count); end
        set_beat(1'b1, 10'd12, 1'b0, 32'h99, 32'h0, 1'b0); tick();
        checks++; if ({rd_valid, ld_count} !== {1'b0, 11'd1}) begin errors++;
            $display("FAIL abandon_next got v=%b cnt=%0d exp 0 1", rd_valid, ld_count); end
        set_beat(1'b1, 10'd0, 1'b1, 32'hEE, 32'hEF, 1'b1); load_start = 1'b1; tick(); load_start = 1'b0;
        checks++; if ({ld_count, busy} !== {11'd0, 1'b1}) begin errors++;
            $display("FAIL restart_drop got cnt=%0d busy=%b exp 0 1", ld_count, busy); end
        set_beat(1'b1, 10'd14, 1'b0, 32'h12, 32'h0, 1'b1); tick();
        set_beat(1'b0, '0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if ({ld_count, busy, fetch_ready} !== {11'd1, 2'b01}) begin errors++;
            $display("FAIL restart_done got cnt=%0d busy=%b frdy=%b exp 1 0 1", ld_count, busy, fetch_ready); end
        set_fetch(1'b1, 10'd0, 1'b1); tick();
        checks++; if ({rd_data0, rd_data1} !== {32'h11, 32'h22}) begin errors++;
            $display("FAIL drop_nowrite got %h/%h exp 11/22", rd_data0, rd_data1); end
        set_fetch(1'b1, 10'd12, 1'b0); tick();
        checks++; if ({rd_valid, rd_data0} !== {1'b1, 32'h99}) begin errors++;
            $display("FAIL word12 got v=%b %h exp 1 99", rd_valid, rd_data0); end
        set_fetch(1'b1, 10'd14, 1'b0); tick(); set_fetch(1'b0, '0, 1'b0);
        checks++; if ({rd_valid, rd_data0} !== {1'b1, 32'h12}) begin errors++;
            $display("FAIL word14 got v=%b %h exp 1 12", rd_valid, rd_data0); end
    endtask

    task automatic test_reset_mid_load();
        load_start = 1'b1; tick(); load_start = 1'b0;
        set_beat(1'b1, 10'd20, 1'b1, 32'hA1, 32'hA2, 1'b0); tick();
        set_beat(1'b1, 10'd22, 1'b0, 32'hA3, 32'h0, 1'b0); tick();
        set_beat(1'b0, '0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if (ld_count !== 11'd3) begin errors++; $display("FAIL mid_count got %0d exp 3", ld_count); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if ({busy, ld_ready, fetch_ready, ld_count} !== {3'b000, 11'd0}) begin errors++;
            $display("FAIL mid_reset got busy=%b rdy=%b frdy=%b cnt=%0d exp 0 0 0 0", busy, ld_ready, fetch_ready, ld_count); end
        load_start = 1'b1; tick(); load_start = 1'b0;
        set_beat(1'b1, 10'd30, 1'b0, 32'hB0, 32'h0, 1'b1); tick();
        set_beat(1'b0, '0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_fetch(1'b1, 10'd20, 1'b1); tick();
        checks++; if ({rd_valid, rd_data0, rd_data1} !== {1'b1, 32'hA1, 32'hA2}) begin errors++;
            $display("FAIL retain20 got v=%b %h/%h exp 1 a1/a2", rd_valid, rd_data0, rd_data1); end
        set_fetch(1'b1, 10'd22, 1'b0); tick(); set_fetch(1'b0, '0, 1'b0);
        checks++; if ({rd_valid, rd_data0, rd_data1} !== {1'b1, 32'hA3, 32'h0}) begin errors++;
            $display("FAIL retain22 got v=%b %h/%h exp 1 a3/0", rd_valid, rd_data0, rd_data1); end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_odd_pair();
        test_top_boundary();
        test_blocked_and_b2b();
        test_abandon_restart();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_dual_bank.md
Name: imem_dual_bank

Overview:
- Parametrised successor to the single-array instruction memory.
- Holds the program image in two interleaved even/odd banks, loaded through a valid/ready load port with a small load-sequencing FSM.
- Serves one- or two-word fetches with registered 1-cycle latency.
- Sits between the PC/fetch stage and the external program-loader (ex-mem) interface; fetch is blocked while a load is in progress.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 1024, total words; must be a power of two and at least 4.
- ADDR_W, $clog2(DEPTH), word-address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- load_start  in  1  pulse; begins or restarts a load session.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat accepted when ld_valid&&ld_ready.
- ld_addr  in  ADDR_W  word address of the first word in the beat.
- ld_pair  in  1  1 = beat writes two words (ld_data0 at ld_addr, ld_data1 at ld_addr+1); 0 = ld_data0 only.
- ld_data0  in  DATA_W  first word.
- ld_data1  in  DATA_W  second word.
- ld_last  in  1  final beat of the session.
- ld_count  out  ADDR_W+1  words written this session.
- ld_err  out  1  sticky; set if any pair beat straddles the top of memory.
- busy  out  1  high in LOAD.
- fetch_req  in  1  fetch request.
- fetch_ready  out  1  high only in RUN.
- fetch_addr  in  ADDR_W  word address (PC).
- fetch_pair  in  1  1 = return addr and addr+1; 0 = addr only.
- rd_valid  out  1  read data valid.
- rd_data0  out  DATA_W  word at fetch_addr.
- rd_data1  out  DATA_W  word at fetch_addr+1 (wraps mod DEPTH); 0 when fetch_pair=0.

Behaviour:
- Reset: state IDLE; ld_ready=0, busy=0, fetch_ready=0, rd_valid=0, rd_data0/1=0, ld_count=0, ld_err=0. Memory contents are not cleared.
- FSM states are IDLE, LOAD and RUN.
  - IDLE: load_start goes to LOAD; all else is ignored.
  - LOAD: ld_ready=1, busy=1. An accepted beat with ld_last=1 goes to RUN on the next edge.
  - RUN: load_start goes to LOAD.
  - Any state: load_start has priority over every other input in the same cycle.
- Load session start: load_start clears ld_count and ld_err in the same edge it enters LOAD. load_start while already in LOAD restarts the session the same way; any beat presented in that cycle is dropped.
- Bank mapping: bank = addr[0], row = addr[ADDR_W-1:1].
- Pair-write routing:
  - Even ld_addr: data0 goes to bank0[row], data1 to bank1[row].
  - Odd ld_addr: data0 goes to bank1[row], data1 to bank0[row+1].
  - Both words are written on the accept edge.
- Top-of-memory boundary: a pair beat with ld_addr=DEPTH-1 writes data0 only, sets ld_err and does not wrap. ld_count counts words actually written.
- Fetch rules:
  - Accepted only when fetch_req&&fetch_ready.
  - rd_valid goes high exactly 1 cycle after acceptance; rd_data is registered.
  - Back-to-back fetches every cycle are allowed.
  - rd_valid=0 in any cycle after a non-accepted cycle.
  - rd_data holds its last value while rd_valid=0.
- Fetch wrap: fetch_pair at DEPTH-1 returns word DEPTH-1 and word 0.
- Fetch abandoned by load: load_start while a fetch is outstanding still delivers that one registered result (rd_valid=1 in the first LOAD cycle). No new fetch is accepted in LOAD.
- Reset mid-load: returns to IDLE, session counters cleared, already-written words retained.

Decomposition:
- imem_pkg holds:
  - the state enum (IDLE, LOAD, RUN);
  - default DATA_W/DEPTH constants;
  - a function computing the bank/row split of an address.
- Sub-module imem_bank: 1-write/1-read synchronous RAM of DEPTH/2 x DATA_W with registered read; instantiated twice (even, odd).
- The top level holds the FSM, write/read steering and the counters.

Test Plan:
- Reset, then load_start, then 2 pair beats (addr 0: 0x11/0x22; addr 2: 0x33/0x44, ld_last) -> ld_count=4, ld_err=0, busy falls one cycle after the last accept; pair fetch at 1 -> next cycle rd_valid=1, rd_data0=0x22, rd_data1=0x33.
- Odd-address pair write at 5 (0xAA/0xBB) -> pair fetch at 5 returns 0xAA/0xBB; single fetch at 6 returns rd_data0=0xBB, rd_data1=0.
- Pair beat at DEPTH-1 (0xCC/0xDD) -> ld_err=1, ld_count increments by 1; pair fetch at DEPTH-1 returns 0xCC and the word at 0.
- fetch_req held in IDLE and in LOAD -> fetch_ready=0, rd_valid stays 0; back-to-back fetches in RUN -> rd_valid high every cycle with correct per-address data.
- load_start during RUN with an outstanding fetch -> that result is delivered and busy=1; load_start again mid-LOAD with a beat -> beat dropped, ld_count=0.
- rst asserted mid-session after 3 words -> state IDLE, ld_count=0; new session without rewriting -> the earlier 3 words still read correctly.
